// File: rtl/neopixel_pkg.sv
// Shared constants and types for the NeoPixel AXI4-Lite controller.
package neopixel_pkg;

  // Word offsets (byte address [4:2]).
  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_COLOR   = 3'd1;
  localparam logic [2:0] OFF_NPIX    = 3'd2;
  localparam logic [2:0] OFF_SCRATCH = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;

  // Default WS2812 timing at 100 MHz.
  localparam int DEF_T0H_CYCLES  = 40;
  localparam int DEF_T1H_CYCLES  = 80;
  localparam int DEF_TBIT_CYCLES = 125;
  localparam int DEF_TRST_CYCLES = 5000;

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, RESET} ser_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/neopixel_serializer.sv
// WS2812 bit serializer: sends a snapshotted GRB word num_pix times, then a low latch gap.
module neopixel_serializer
  import neopixel_pkg::*;
#(
  parameter int T0H_CYCLES  = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES  = DEF_T1H_CYCLES,
  parameter int TBIT_CYCLES = DEF_TBIT_CYCLES,
  parameter int TRST_CYCLES = DEF_TRST_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] color,
  input  logic [7:0]  num_pix,
  output logic        dout,
  output logic        busy,
  output logic        fin
);

  localparam int CMAX = (TRST_CYCLES > TBIT_CYCLES) ? TRST_CYCLES : TBIT_CYCLES;
  localparam int CW   = $clog2(CMAX);

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic [7:0]    pix, npix;
  logic [23:0]   col, sh;
  logic [CW-1:0] th_m1;

  assign th_m1 = sh[23] ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);

  // cnt runs across a whole bit period (HIGH then LOW), so the next bit or
  // pixel reload starts straight from LOW without an extra LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      pix     <= '0;
      npix    <= '0;
      col     <= '0;
      sh      <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: if (start) begin
          col   <= color;
          npix  <= num_pix;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          cnt     <= '0;
          pix     <= '0;
          bit_idx <= 5'd23;
          sh      <= col;
          if (npix == 8'd0) state <= RESET;
          else begin
            dout  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          cnt <= cnt + CW'(1);
          if (cnt == th_m1) begin
            dout  <= 1'b0;
            state <= LOW;
          end
        end
        LOW: begin
          if (cnt == CW'(TBIT_CYCLES - 1)) begin
            cnt <= '0;
            if (bit_idx != 5'd0) begin
              bit_idx <= bit_idx - 5'd1;
              sh      <= {sh[22:0], 1'b0};
              dout    <= 1'b1;
              state   <= HIGH;
            end else if (pix == npix - 8'd1) begin
              state <= RESET;
            end else begin
              pix     <= pix + 8'd1;
              bit_idx <= 5'd23;
              sh      <= col;
              dout    <= 1'b1;
              state   <= HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESET: begin
          if (cnt == CW'(TRST_CYCLES - 1)) begin
            busy  <= 1'b0;
            fin   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/neopixel_axil_ctrl.sv
// AXI4-Lite register block driving a WS2812 line. Define NEOPIXEL_IRQ_EN to add
// an end-of-frame irq output gated by CTRL[1].
module neopixel_axil_ctrl
  import neopixel_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int T0H_CYCLES         = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES         = DEF_T1H_CYCLES,
  parameter int TBIT_CYCLES        = DEF_TBIT_CYCLES,
  parameter int TRST_CYCLES        = DEF_TRST_CYCLES
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
`ifdef NEOPIXEL_IRQ_EN
  output logic                            irq,
`endif
  output logic                            dout,
  output logic                            busy
);

  logic [31:0] regs [4];
  logic        wr_rdy, rd_rdy, wr_fire, launch, start, done, fin;
  logic [2:0]  widx, ridx;
  logic [31:0] rd_word;

  assign s00_axi_awready = wr_rdy;
  assign s00_axi_wready  = wr_rdy;
  assign s00_axi_arready = rd_rdy;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rresp   = 2'b00;

  assign widx    = s00_axi_awaddr[4:2];
  assign ridx    = s00_axi_araddr[4:2];
  assign wr_fire = wr_rdy && s00_axi_awvalid && s00_axi_wvalid;
  assign launch  = wr_fire && (widx == OFF_CTRL) && s00_axi_wstrb[0] &&
                   s00_axi_wdata[0] && !busy;

  always_comb begin
    rd_word = '0;
    if (!ridx[2])                rd_word = regs[ridx[1:0]];
    else if (ridx == OFF_STATUS) rd_word = {30'd0, done, busy};
  end

  // Write channel, register file, start pulse and sticky done.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_rdy         <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      start          <= 1'b0;
      done           <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      wr_rdy <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !wr_rdy;
      if (wr_fire)             s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
      if (wr_fire && !widx[2])
        regs[widx[1:0]] <= apply_wstrb(regs[widx[1:0]], s00_axi_wdata, s00_axi_wstrb);
      start <= launch;
      if (fin)                                            done <= 1'b1;
      else if (launch || (wr_fire && widx == OFF_STATUS)) done <= 1'b0;
    end
  end

  // Read channel; rd_word is sampled before this edge's register writes land.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_rdy         <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
    end else begin
      rd_rdy <= s00_axi_arvalid && !s00_axi_rvalid && !rd_rdy;
      if (rd_rdy && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  neopixel_serializer #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .TBIT_CYCLES(TBIT_CYCLES),
    .TRST_CYCLES(TRST_CYCLES)
  ) u_ser (
    .clk    (s00_axi_aclk),
    .rst_n  (s00_axi_aresetn),
    .start  (start),
    .color  (regs[OFF_COLOR[1:0]][23:0]),
    .num_pix(regs[OFF_NPIX[1:0]][7:0]),
    .dout   (dout),
    .busy   (busy),
    .fin    (fin)
  );

`ifdef NEOPIXEL_IRQ_EN
  assign irq = fin && regs[OFF_CTRL[1:0]][1];
`endif

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_awprot,
                         s00_axi_arprot, regs[OFF_CTRL[1:0]][31:1],
                         regs[OFF_COLOR[1:0]][31:24], regs[OFF_NPIX[1:0]][31:8]};

endmodule

// File: tb/tb_neopixel_axil_ctrl.sv
// Directed + randomized bench for neopixel_axil_ctrl with a register/frame reference model.
module tb_neopixel_axil_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, dout, busy;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  neopixel_axil_ctrl dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle stamps of dout / busy edges, sampled on the falling clock edge.
  int   cyc = 0;
  int   rises[$], falls[$], brises[$], bfalls[$];
  logic dout_q = 1'b0, busy_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dout && !dout_q) rises.push_back(cyc);
    if (!dout && dout_q) falls.push_back(cyc);
    if (busy && !busy_q) brises.push_back(cyc);
    if (!busy && busy_q) bfalls.push_back(cyc);
    dout_q <= dout;
    busy_q <= busy;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ok(input string tag, input logic cond);
    chk(tag, {31'd0, cond}, 32'd1);
  endtask

  // Reference model: stored registers plus the sticky done flag.
  logic [31:0] m_regs [4];
  logic        m_done = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_expect(input logic [4:0] a, input logic bexp);
    if (a < 5'h10)       return m_regs[a[3:2]];
    else if (a == 5'h10) return {30'd0, m_done, bexp};
    else                 return 32'd0;
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int hs);
    int t;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    t = 0;
    while (!(awready && wready) && t < 50) begin @(negedge clk); t++; end
    chk_ok("aw_handshake", t < 50);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    hs = cyc;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    chk_ok("bvalid_wait", t < 50);
    chk("bresp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int t;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk_ok("ar_handshake", t < 50);
    @(posedge clk); #1;
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    chk_ok("rvalid_wait", t < 50);
    d = rdata;
    chk("rresp", {30'd0, rresp}, 32'd0);
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic mwrite(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int hs);
    axi_write(a, d, s, hs);
    if (a < 5'h10)       m_regs[a[3:2]] = merge(m_regs[a[3:2]], d, s);
    else if (a == 5'h10) m_done = 1'b0;
  endtask

  task automatic mread(input string tag, input logic [4:0] a, input logic bexp);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, m_expect(a, bexp));
  endtask

  task automatic clear_log();
    rises.delete(); falls.delete(); brises.delete(); bfalls.delete();
  endtask

  task automatic launch(input logic [23:0] col, input logic [7:0] n, output int hs);
    int dmy;
    mwrite(5'h04, {8'h00, col}, 4'hF, dmy);
    mwrite(5'h08, {24'd0, n}, 4'hF, dmy);
    clear_log();
    mwrite(5'h00, 32'd1, 4'hF, hs);
    m_done = 1'b0;
  endtask

  // Waits for the frame to end, then checks every bit against the WS2812 rules.
  task automatic finish_frame(input int hs, input logic [23:0] col, input int n);
    int t, budget, flen;
    logic b;
    flen   = n * 24 * 125 + 5000 + 1;
    budget = flen + 200;
    t = 0;
    @(negedge clk);
    while ((busy || cyc < hs + 2) && t < budget) begin @(negedge clk); t++; end
    chk_ok("frame_timeout", t < budget);
    repeat (2) @(negedge clk);
    chk("busy_rise", brises.size() > 0 ? brises[0] : -1, hs + 1);
    chk("busy_fall", bfalls.size() > 0 ? bfalls[0] : -1, hs + flen + 1);
    chk("bit_count", rises.size(), 24 * n);
    chk("fall_count", falls.size(), rises.size());
    for (int i = 0; i < rises.size() && i < 24 * n && i < falls.size(); i++) begin
      b = col[23 - (i % 24)];
      chk($sformatf("bit%0d_start", i), rises[i], hs + 2 + i * 125);
      chk($sformatf("bit%0d_high", i), falls[i] - rises[i], b ? 80 : 40);
    end
    m_done = 1'b1;
  endtask

  initial begin
    int          hs, hs2, dmy, t;
    logic [31:0] rd, exp_rd, d;
    logic [23:0] col;
    logic [7:0]  n;
    logic [4:0]  a;
    logic [3:0]  s;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_wready",  {31'd0, wready},  0);
    chk("rst_bvalid",  {31'd0, bvalid},  0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_rvalid",  {31'd0, rvalid},  0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_dout",    {31'd0, dout}, 0);
    chk("rst_busy",    {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Register readback; CTRL=1 with NUM_PIXELS still 0 launches an empty frame.
    clear_log();
    mwrite(5'h00, 32'h1, 4'hF, hs);
    m_done = 1'b0;
    mwrite(5'h04, 32'h2, 4'hF, dmy);
    mwrite(5'h08, 32'h3, 4'hF, dmy);
    mwrite(5'h0C, 32'h4, 4'hF, dmy);
    mread("rb_ctrl", 5'h00, 1'b1);
    mread("rb_color", 5'h04, 1'b1);
    mread("rb_npix", 5'h08, 1'b1);
    mread("rb_scratch", 5'h0C, 1'b1);
    mread("status_busy0", 5'h10, 1'b1);
    finish_frame(hs, 24'h0, 0);
    mread("status_done0", 5'h10, 1'b0);

    // Single pixel, MSB-only colour
    launch(24'h800000, 8'd1, hs);
    finish_frame(hs, 24'h800000, 1);
    mread("status_done1", 5'h10, 1'b0);

    // Relaunch while busy is ignored; launch clears done
    launch(24'h0F0F0F, 8'd1, hs);
    repeat (700) @(negedge clk);
    mread("status_mid", 5'h10, 1'b1);
    mwrite(5'h00, 32'h1, 4'hF, hs2);
    mread("ctrl_busy_wr", 5'h00, 1'b1);
    finish_frame(hs, 24'h0F0F0F, 1);
    mread("status_done2", 5'h10, 1'b0);
    mwrite(5'h10, 32'hDEAD_BEEF, 4'hF, dmy);
    mread("status_clr", 5'h10, 1'b0);

    // Byte strobes
    mwrite(5'h0C, 32'h0, 4'hF, dmy);
    mwrite(5'h0C, 32'hAABB_CCDD, 4'b0010, dmy);
    mread("wstrb_scratch", 5'h0C, 1'b0);

    // Concurrent read and write of the same register
    exp_rd = m_regs[3];
    fork
      mwrite(5'h0C, 32'h1234_5678, 4'hF, dmy);
      axi_read(5'h0C, rd);
    join
    chk("rw_pre_value", rd, exp_rd);
    mread("rw_post_value", 5'h0C, 1'b0);

    // Random register traffic (CTRL bit0 kept clear so nothing launches)
    for (int i = 0; i < 24; i++) begin
      a = {3'($urandom_range(0, 7)), 2'b00};
      d = $urandom;
      s = 4'($urandom);
      if (a == 5'h00) d[0] = 1'b0;
      mwrite(a, d, s, dmy);
      a = {3'($urandom_range(0, 7)), 2'b00};
      mread($sformatf("rand_rd_%0d", i), a, 1'b0);
    end

    // Random frames
    for (int i = 0; i < 2; i++) begin
      col = 24'($urandom);
      n   = 8'($urandom_range(1, 3));
      launch(col, n, hs);
      finish_frame(hs, col, int'(n));
      mread($sformatf("rand_status_%0d", i), 5'h10, 1'b0);
    end

    // Reset in the middle of a high pulse
    launch(24'hFFFFFF, 8'd2, hs);
    t = 0;
    @(negedge clk);
    while (!dout && t < 200) begin @(negedge clk); t++; end
    chk_ok("dout_high_wait", t < 200);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", {31'd0, dout}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mread($sformatf("post_rst_%0d", i), 5'(i * 4), 1'b0);
    repeat (10) @(negedge clk);
    chk("post_rst_dout", {31'd0, dout}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_axil_ctrl.md
# neopixel_axil_ctrl

AXI4-Lite responder for the NeoPixel IP: decodes register writes and reads issued by the PS/VIP master and drives a WS2812 serial data line. Four read/write registers plus one read-only status register. A write of CTRL[0]=1 launches a frame that sends the COLOR word NUM_PIXELS times, then a latch/reset gap. Sits between the AXI interconnect and the `dout` package pin.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 5, byte address width (8 word slots)
- T0H_CYCLES, 40, high time of a 0 bit (0.4 us @ 100 MHz)
- T1H_CYCLES, 80, high time of a 1 bit
- TBIT_CYCLES, 125, full bit period
- TRST_CYCLES, 5000, low latch gap after last pixel (50 us)
- s00_axi_aclk  in  1  single clock
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  5/3/1/1  write address channel
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  5/3/1/1  read address channel
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
- dout  out  1  WS2812 serial line
- busy  out  1  frame in progress

## Operation
- Map (word offset): 0x00 CTRL, 0x04 COLOR (GRB in [23:0]), 0x08 NUM_PIXELS ([7:0] used), 0x0C SCRATCH, 0x10 STATUS (RO: [0]=busy, [1]=done sticky). 0x14–0x1C: writes ignored, read 0.
- Registers 0x00–0x0C store all 32 bits written, honouring WSTRB per byte; read back exactly what was written.
- Launch: accepted write to CTRL with wdata[0]=1 (and wstrb[0]=1) while idle → one-cycle start pulse; COLOR and NUM_PIXELS snapshotted. While busy, register still updates, launch ignored.
- Serializer FSM: IDLE → LOAD (latch 24-bit shift reg, bit index 23) → HIGH (dout=1 for T0H/T1H per MSB) → LOW (dout=0 until TBIT elapsed) → next bit, or next pixel (reload) if bit 0 done, or RESET if pixel counter reaches NUM_PIXELS → IDLE after TRST_CYCLES low.
- NUM_PIXELS=0: skip directly to RESET gap.
- done sticky bit sets on RESET→IDLE; cleared by a write to STATUS offset (any data) or by next launch.
- bresp/rresp always OKAY (2'b00).

## Timing
- Reset: all AXI ready/valid low, bresp/rresp/rdata 0, all registers 0, dout 0, busy 0, FSM IDLE.
- Write: awready and wready asserted together for one cycle when awvalid && wvalid && !bvalid; register updated that edge; bvalid next cycle, held until bready.
- Read: arready one cycle when arvalid && !rvalid; rvalid+rdata next cycle, held stable until rready.
- Simultaneous read and write same cycle both accepted; read returns pre-write value.
- Start pulse → dout rises 2 cycles after the CTRL write handshake edge; busy rises same cycle as LOAD.
- Frame length = NUM_PIXELS·24·TBIT + TRST + 1 (LOAD per pixel absorbed into LOW phase of previous bit).
- Reset mid-frame: dout forced 0 immediately (async), FSM to IDLE.

## Configuration
- NEOPIXEL_IRQ_EN defined: extra output `irq` (1 bit) pulses high one cycle on RESET→IDLE; CTRL[1] masks it (1=enabled).
- Undefined: no `irq` port, CTRL[1] stored but has no effect.

## Structure
- Package neopixel_pkg: register offset constants, serializer state enum (IDLE, LOAD, HIGH, LOW, RESET), default timing constants.
- Sub-module neopixel_serializer: FSM, bit/pixel/cycle counters, dout; top holds AXI logic and registers.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00–0x0C, read back → 0x1,0x2,0x3,0x4, resp OKAY.
- COLOR=0x800000, NUM_PIXELS=1, CTRL=1 → first bit high 80 cycles, next 23 bits high 40 cycles, 125-cycle period, then 5000 cycles low, STATUS=0x2.
- NUM_PIXELS=0, CTRL=1 → dout stays 0, busy 5000+ cycles, done set.
- CTRL=1 written again while busy → frame length unchanged, no restart.
- WSTRB=4'b0010 write 0xAABBCCDD to SCRATCH=0 → read 0x0000CC00.
- Assert aresetn low mid-bit with dout=1 → dout=0 same cycle, busy=0, registers 0.
